// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared op encodings, flag indices and pipeline-depth helper for
//            the segmented add/subtract unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    localparam int FLAG_V  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_N  = 3;
    localparam int FLAGS_W = 4;

    // Per-beat side information travelling down the pipe with the operands.
    typedef struct packed {
        logic sat;
        logic sign_a;
        logic sign_b;
    } meta_t;

    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_seg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_seg
// Brief    : Registered SEG_W-bit adder slice with carry in/out and a valid
//            bit; all state advances only when en_i is high.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_seg #(
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    output logic             valid_o,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);

    logic [SEG_W:0]   sum_d;
    logic [SEG_W-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    always_comb begin
        sum_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= sum_d[SEG_W-1:0];
            cout_q  <= sum_d[SEG_W];
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;

endmodule
`default_nettype wire

// File: rtl/alu_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_addsub_pipe
// Brief    : Pipelined ADD/SUB/ADC/SBC unit, one carry segment per stage, with
//            {N,Z,C,V} flags and valid/ready on both sides. Optional signed
//            saturation is enabled by defining ADDSUB_SAT_EN (adds port sat_i).
// Revision : 1.0 - initial release
// ============================================================================
module alu_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         op_i,
    input  logic               cin_i,
`ifdef ADDSUB_SAT_EN
    input  logic               sat_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   result_o,
    output logic [FLAGS_W-1:0] flags_o
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    generate
        if ((WIDTH % SEG_W) != 0 || NSEG < 1 || NSEG > 8) begin : g_param_check
            $error("alu_addsub_pipe: WIDTH must be SEG_W times 1..8");
        end
    endgenerate

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;
    logic             sat_in;
    meta_t            meta_in;

    // Stage k consumes the low segment of opa_w[k]/opb_w[k]; the remainder is
    // shifted down into opa_q[k] so the next stage again reads the low bits.
    logic [WIDTH-1:0] opa_w  [NSEG];
    logic [WIDTH-1:0] opb_w  [NSEG];
    logic [WIDTH-1:0] opa_q  [NSEG];
    logic [WIDTH-1:0] opb_q  [NSEG];
    logic [WIDTH-1:0] res_q  [NSEG];
    logic [WIDTH-1:0] acc_w  [NSEG];
    meta_t            meta_q [NSEG];
    logic             seg_cin  [NSEG];
    logic             seg_vin  [NSEG];
    logic             seg_vld  [NSEG];
    logic [SEG_W-1:0] seg_sum  [NSEG];
    logic             seg_cout [NSEG];

    // No bubble collapsing: the whole pipe stalls only when the output is held.
    assign adv        = !out_valid_o || out_ready_i;
    assign in_ready_o = adv;

`ifdef ADDSUB_SAT_EN
    assign sat_in = sat_i;
`else
    assign sat_in = 1'b0;
`endif

    always_comb begin
        b_eff  = b_i;
        carry0 = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                b_eff  = b_i;
                carry0 = 1'b0;
            end
            OP_SUB: begin
                b_eff  = ~b_i;
                carry0 = 1'b1;
            end
            OP_ADC: begin
                b_eff  = b_i;
                carry0 = cin_i;
            end
            OP_SBC: begin
                b_eff  = ~b_i;
                carry0 = cin_i;
            end
            default: begin
                b_eff  = b_i;
                carry0 = 1'b0;
            end
        endcase
    end

    assign meta_in = '{sat: sat_in, sign_a: a_i[WIDTH-1], sign_b: b_eff[WIDTH-1]};

    generate
        for (genvar k = 0; k < NSEG; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign opa_w[k]   = a_i;
                assign opb_w[k]   = b_eff;
                assign seg_cin[k] = carry0;
                assign seg_vin[k] = in_valid_i;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        res_q[k]  <= '0;
                        meta_q[k] <= '0;
                    end else if (adv) begin
                        res_q[k]  <= '0;
                        meta_q[k] <= meta_in;
                    end
                end
            end else begin : g_body
                assign opa_w[k]   = opa_q[k-1];
                assign opb_w[k]   = opb_q[k-1];
                assign seg_cin[k] = seg_cout[k-1];
                assign seg_vin[k] = seg_vld[k-1];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        res_q[k]  <= '0;
                        meta_q[k] <= '0;
                    end else if (adv) begin
                        res_q[k]  <= acc_w[k-1];
                        meta_q[k] <= meta_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    opa_q[k] <= '0;
                    opb_q[k] <= '0;
                end else if (adv) begin
                    opa_q[k] <= opa_w[k] >> SEG_W;
                    opb_q[k] <= opb_w[k] >> SEG_W;
                end
            end

            addsub_seg #(
                .SEG_W (SEG_W)
            ) u_seg (
                .clk     (clk),
                .rst     (rst),
                .en_i    (adv),
                .valid_i (seg_vin[k]),
                .a_i     (opa_w[k][SEG_W-1:0]),
                .b_i     (opb_w[k][SEG_W-1:0]),
                .cin_i   (seg_cin[k]),
                .valid_o (seg_vld[k]),
                .sum_o   (seg_sum[k]),
                .cout_o  (seg_cout[k])
            );

            assign acc_w[k] = res_q[k] | (WIDTH'(seg_sum[k]) << (k * SEG_W));
        end
    endgenerate

    logic [WIDTH-1:0]   res_raw;
    logic [WIDTH-1:0]   res_fin;
    logic               ovf;
    meta_t              meta_out;
    logic [FLAGS_W-1:0] flags_w;

    assign res_raw  = acc_w[NSEG-1];
    assign meta_out = meta_q[NSEG-1];

    // Clamp sits after the last register so latency is the same with or
    // without saturation; N/Z follow the clamped value, C/V the raw sum.
    always_comb begin
        ovf     = (meta_out.sign_a == meta_out.sign_b) &&
                  (res_raw[WIDTH-1] != meta_out.sign_a);
        res_fin = res_raw;
        if (meta_out.sat && ovf) begin
            res_fin = meta_out.sign_a ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
        flags_w         = '0;
        flags_w[FLAG_N] = res_fin[WIDTH-1];
        flags_w[FLAG_Z] = (res_fin == '0);
        flags_w[FLAG_C] = seg_cout[NSEG-1];
        flags_w[FLAG_V] = ovf;
    end

    assign out_valid_o = seg_vld[NSEG-1];
    assign result_o    = res_fin;
    assign flags_o     = out_valid_o ? flags_w : '0;

endmodule
`default_nettype wire

// File: doc/alu_addsub_pipe.md
Name: alu_addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the ALU single-cycle registered 16-bit adder.
- Carry chain is split into SEG_W-bit segments, one pipeline stage per segment, so WIDTH scales without a timing hit.
- Adds ops (ADD/SUB/ADC/SBC), status flags and valid/ready handshakes on both sides.
- Sits between the ALU operand mux and the result writeback stage.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG_W.
- SEG_W, 8, carry-segment width; NSEG = WIDTH/SEG_W = pipeline depth (1..8).

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- cin  in  1  carry in; used by ADC/SBC only.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- flags  out  4  {N,Z,C,V}.

Behaviour:
- Reset (async, rst=1): all stage valids=0, out_valid=0, result=0, flags=0; in_ready=1 on the first cycle after release. Any beats in flight are discarded without output.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Once asserted, out_valid, result and flags hold stable until the output transfer.
- Pipeline advance: adv = !out_valid | out_ready; in_ready = adv. All stages shift together on adv; no bubble collapsing, so the global stall is simple.
- Latency: exactly NSEG cycles from input transfer to out_valid when unstalled. Throughput 1 beat/cycle.
- Arithmetic:
  - Effective B: SUB/SBC use ~b.
  - Carry-in: ADD 0, SUB 1, ADC cin, SBC cin (cin=1 means no borrow).
  - Stage k adds segment k with the carry registered from stage k-1. Upper-segment operands are delayed through the pipe alongside.
- Flags:
  - C = carry out of MSB. For SUB it is 1 when there is no borrow, i.e. a>=b unsigned.
  - V = signed overflow (operand sign bits equal, result sign differs, using effective B).
  - N = result[WIDTH-1]; Z = (result==0).
- Boundaries:
  - Wrap-around is modulo 2^WIDTH.
  - Simultaneous output transfer and new input in the same cycle is legal: full throughput.
  - in_valid=0 injects a bubble (stage valid=0); bubbles are never presented on the output.
  - op/cin are captured with the beat; later changes do not affect it.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined:
  - Extra input port sat (1), captured with the beat.
  - When sat=1 and V=1, result clamps to the signed max (0111..1) or signed min (1000..0), chosen by the sign of A.
  - V still reports the overflow; C is unchanged; N and Z are computed on the clamped value.
  - Clamp is applied in the final stage, so latency does not change.
- Undefined: no sat port; results always wrap.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants OP_ADD/OP_SUB/OP_ADC/OP_SBC;
  - flag bit indices FLAG_N/FLAG_Z/FLAG_C/FLAG_V;
  - the NSEG derivation.
- One sub-module, addsub_seg: a registered SEG_W-bit segment adder with carry-in/out, valid and enable. The top instantiates NSEG of these plus the delay lines and the flag/saturation logic.

Test Plan (WIDTH=16, SEG_W=8):
- ADD 0x0003+0x0004, out_ready=1 -> after 2 cycles result=0x0007, flags=0000.
- ADD 0xFFFF+0x0001 -> result=0x0000, Z=1, C=1, V=0, N=0. ADD 0x7FFF+0x0001 -> result=0x8000, N=1, V=1, C=0.
- SUB 0x0003-0x0004 -> 0xFFFF, N=1, C=0. SBC 0x1000-0x0001 with cin=0 -> 0x0FFE, C=1.
- Back-to-back stream of 8 beats with out_ready toggling 1,0,0,1... -> every result in order, none dropped or duplicated; result held stable while stalled; in_ready=0 exactly when out_valid&!out_ready.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0, result=0 immediately (async); no stale output afterwards; next beat 0x0001+0x0001 -> 0x0002.
- (ADDSUB_SAT_EN) ADD sat=1 0x7FFF+0x0001 -> 0x7FFF, V=1. ADD sat=1 0x8000+0xFFFF -> 0x8000, V=1.
